// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store access controller.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  // Reserved encoding 3 behaves exactly as WORD.
  function automatic size_t norm_size(input logic [1:0] raw);
    size_t s;
    if (raw == 2'd3) s = SZ_WORD;
    else             s = size_t'(raw);
    return s;
  endfunction

  function automatic logic is_aligned(input size_t size, input logic [1:0] off);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~off[0];
      default: ok = (off == 2'b00);
    endcase
    return ok;
  endfunction

  // Lane offset once the bits a given size cannot use are cleared.
  function automatic logic [1:0] eff_offset(input size_t size, input logic [1:0] off);
    logic [1:0] o;
    case (size)
      SZ_BYTE: o = off;
      SZ_HALF: o = {off[1], 1'b0};
      default: o = 2'b00;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Lane logic: little-endian sub-word extract/extend for loads and merge for stores.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] ld_val,
  output logic [31:0] st_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b  = word[{offset, 3'b000} +: 8];
    lane_h  = offset[1] ? word[31:16] : word[15:0];
    ld_val  = word;
    st_word = wdata;
    case (size_t'(size))
      SZ_BYTE: begin
        ld_val  = {{24{~uns & lane_b[7]}}, lane_b};
        st_word = word;
        st_word[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        ld_val  = {{16{~uns & lane_h[15]}}, lane_h};
        st_word = word;
        st_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_access_ctrl.sv
// Load/store access controller between the datapath and a word-addressed memory.
// Build option LSU_ALIGN_CHECK_EN: misaligned requests return rsp_err instead of being force-aligned.
module lsu_access_ctrl
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  // state | meaning
  // IDLE  | waiting for a request, req_ready high
  // RD    | memory word read: load extract or store merge
  // WR    | mem_we high for exactly one cycle
  // RESP  | response held until rsp_ready

  state_t        state, state_d;
  logic          st_q, st_d;
  size_t         size_q, size_d;
  logic          uns_q, uns_d;
  logic [1:0]    off_q, off_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          mem_we_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d;
  logic          rsp_valid_d;
  logic [DW-1:0] rsp_rdata_d;
  logic          rsp_err_d;

  logic [DW-1:0] ld_val, st_word;
  size_t         req_sz;
  logic          accept;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign req_sz    = norm_size(req_size);

  lsu_lane u_lane (
    .word    (mem_rdata),
    .size    (size_q),
    .offset  (off_q),
    .uns     (uns_q),
    .wdata   (wdata_q),
    .ld_val  (ld_val),
    .st_word (st_word)
  );

  always_comb begin
    state_d     = state;
    st_d        = st_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    case (state)
      IDLE: begin
        if (accept) begin
          st_d        = req_we;
          size_d      = req_sz;
          uns_d       = req_unsigned;
          wdata_d     = req_wdata;
          off_d       = eff_offset(req_sz, req_addr[1:0]);
          mem_addr_d  = {req_addr[AW-1:2], 2'b00};
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
          if (!is_aligned(req_sz, req_addr[1:0])) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else
`endif
          if (req_we && (req_sz == SZ_WORD)) begin
            // Full-word stores need no read, so skip straight to the write.
            state_d     = WR;
            mem_we_d    = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (st_q) begin
          mem_wdata_d = st_word;
          mem_we_d    = 1'b1;
          state_d     = WR;
        end else begin
          rsp_rdata_d = ld_val;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      WR: begin
        rsp_rdata_d = '0;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      st_q      <= 1'b0;
      size_q    <= SZ_BYTE;
      uns_q     <= 1'b0;
      off_q     <= 2'b00;
      wdata_q   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_d;
      st_q      <= st_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      off_q     <= off_d;
      wdata_q   <= wdata_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_lsu_access_ctrl.sv
// Scoreboard bench for lsu_access_ctrl against a small word-addressed memory model.
module tb_lsu_access_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] PRELOAD = 32'h8081_7F01;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'd0;
  logic          req_unsigned = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [31:0] mem [0:15];
  logic        preload = 1'b1;
  int          we_total = 0;

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          we_cyc;
    logic [31:0] word;
  } acc_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          we_cnt;
    int          we_cyc;
    logic [31:0] we_addr;
  } obs_t;

  acc_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  lsu_access_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= (i == 4) ? PRELOAD : 32'h0;
    end else if (mem_we) begin
      mem[mem_addr[5:2]] <= mem_wdata;
    end
  end

  always @(posedge clk) if (mem_we) we_total <= we_total + 1;

  function automatic acc_t mk(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic err, input int lat,
                              input int we_cyc, input logic [31:0] word);
    acc_t a;
    a.we = we; a.sz = sz; a.uns = uns; a.addr = addr; a.wdata = wdata;
    a.rdata = rdata; a.err = err; a.lat = lat; a.we_cyc = we_cyc; a.word = word;
    return a;
  endfunction

  // Drive one request from IDLE, count cycles from the accept edge (= cycle 1), complete the handshake.
  task automatic run_access(input acc_t a, output obs_t o);
    o.rdata = '0; o.err = 1'b0; o.lat = 0; o.we_cnt = 0; o.we_cyc = 0; o.we_addr = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = a.we; req_size = a.sz; req_unsigned = a.uns;
    req_addr = a.addr; req_wdata = a.wdata; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (mem_we) begin o.we_cnt++; o.we_cyc = c; o.we_addr = mem_addr; end
      if (rsp_valid) begin o.lat = c; o.rdata = rsp_rdata; o.err = rsp_err; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; preload = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset req_ready got %b want 1", req_ready); end
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset rsp_valid got %b want 0", rsp_valid); end
    tests_run++; if (rsp_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset rsp_rdata got %h want 0", rsp_rdata); end
    tests_run++; if (rsp_err !== 1'b0) begin tests_failed++; $display("FAIL reset rsp_err got %b want 0", rsp_err); end
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL reset mem_we got %b want 0", mem_we); end
    tests_run++; if (mem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset mem_addr got %h want 0", mem_addr); end
    tests_run++; if (mem_wdata !== 32'h0) begin tests_failed++; $display("FAIL reset mem_wdata got %h want 0", mem_wdata); end
    @(negedge clk);
    preload = 1'b0; reset_n = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset req_ready got %b want 1", req_ready); end
  endtask

  // Shared table runner body is repeated per feature so each test owns its comparisons.
  task automatic test_loads();
    acc_t tbl[$];
    acc_t e;
    obs_t o;
    tbl.push_back(mk(0, 2'd2, 0, 32'h10, 0, 32'h8081_7F01, 0, 2, 0, PRELOAD));
    tbl.push_back(mk(0, 2'd0, 0, 32'h13, 0, 32'hFFFF_FF80, 0, 2, 0, PRELOAD));
    tbl.push_back(mk(0, 2'd0, 1, 32'h13, 0, 32'h0000_0080, 0, 2, 0, PRELOAD));
    tbl.push_back(mk(0, 2'd1, 0, 32'h12, 0, 32'hFFFF_8081, 0, 2, 0, PRELOAD));
    tbl.push_back(mk(0, 2'd1, 1, 32'h12, 0, 32'h0000_8081, 0, 2, 0, PRELOAD));
    tbl.push_back(mk(0, 2'd0, 0, 32'h11, 0, 32'h0000_007F, 0, 2, 0, PRELOAD));
    tbl.push_back(mk(0, 2'd0, 0, 32'h12, 0, 32'hFFFF_FF81, 0, 2, 0, PRELOAD));
    tbl.push_back(mk(0, 2'd0, 1, 32'h10, 0, 32'h0000_0001, 0, 2, 0, PRELOAD));
    tbl.push_back(mk(0, 2'd1, 0, 32'h10, 0, 32'h0000_7F01, 0, 2, 0, PRELOAD));
    tbl.push_back(mk(0, 2'd3, 0, 32'h10, 0, 32'h8081_7F01, 0, 2, 0, PRELOAD));
    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i]);
      run_access(tbl[i], o);
      e = exp_q.pop_front();
      tests_run++; if (o.rdata !== e.rdata) begin tests_failed++; $display("FAIL load@%h sz%0d rdata got %h want %h", e.addr, e.sz, o.rdata, e.rdata); end
      tests_run++; if (o.err !== e.err) begin tests_failed++; $display("FAIL load@%h err got %b want %b", e.addr, o.err, e.err); end
      tests_run++; if (o.lat != e.lat) begin tests_failed++; $display("FAIL load@%h latency got %0d want %0d", e.addr, o.lat, e.lat); end
      tests_run++; if (o.we_cnt != 0) begin tests_failed++; $display("FAIL load@%h mem_we cycles got %0d want 0", e.addr, o.we_cnt); end
      tests_run++; if (mem[4] !== e.word) begin tests_failed++; $display("FAIL load@%h mem word got %h want %h", e.addr, mem[4], e.word); end
    end
  endtask

  task automatic test_stores();
    acc_t tbl[$];
    acc_t e;
    obs_t o;
    tbl.push_back(mk(1, 2'd0, 0, 32'h11, 32'hFFFF_FFAA, 0, 0, 3, 2, 32'h8081_AA01));
    tbl.push_back(mk(1, 2'd2, 0, 32'h10, PRELOAD,       0, 0, 2, 1, PRELOAD));
    tbl.push_back(mk(1, 2'd1, 0, 32'h12, 32'h0000_1234, 0, 0, 3, 2, 32'h1234_7F01));
    tbl.push_back(mk(1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF, 0, 0, 2, 1, 32'hDEAD_BEEF));
    tbl.push_back(mk(1, 2'd0, 0, 32'h13, 32'h0000_0055, 0, 0, 3, 2, 32'h55AD_BEEF));
    tbl.push_back(mk(1, 2'd1, 0, 32'h10, 32'hFFFF_CAFE, 0, 0, 3, 2, 32'h55AD_CAFE));
    tbl.push_back(mk(1, 2'd3, 0, 32'h10, PRELOAD,       0, 0, 2, 1, PRELOAD));
    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i]);
      run_access(tbl[i], o);
      e = exp_q.pop_front();
      tests_run++; if (o.rdata !== e.rdata) begin tests_failed++; $display("FAIL store@%h rdata got %h want %h", e.addr, o.rdata, e.rdata); end
      tests_run++; if (o.lat != e.lat) begin tests_failed++; $display("FAIL store@%h latency got %0d want %0d", e.addr, o.lat, e.lat); end
      tests_run++; if (o.we_cnt != 1) begin tests_failed++; $display("FAIL store@%h mem_we cycles got %0d want 1", e.addr, o.we_cnt); end
      tests_run++; if (o.we_cyc != e.we_cyc) begin tests_failed++; $display("FAIL store@%h mem_we cycle got %0d want %0d", e.addr, o.we_cyc, e.we_cyc); end
      tests_run++; if (o.we_addr !== {e.addr[31:2], 2'b00}) begin tests_failed++; $display("FAIL store@%h mem_addr got %h want %h", e.addr, o.we_addr, {e.addr[31:2], 2'b00}); end
      tests_run++; if (mem[4] !== e.word) begin tests_failed++; $display("FAIL store@%h mem word got %h want %h", e.addr, mem[4], e.word); end
    end
  endtask

  task automatic test_back_to_back();
    acc_t e1, e2, e;
    logic [31:0] held;
    int lat;
    e1 = mk(0, 2'd2, 0, 32'h10, 0, 32'h8081_7F01, 0, 2, 0, PRELOAD);
    e2 = mk(0, 2'd0, 1, 32'h13, 0, 32'h0000_0080, 0, 2, 0, PRELOAD);
    @(negedge clk);
    exp_q.push_back(e1);
    req_valid = 1'b1; req_we = e1.we; req_size = e1.sz; req_unsigned = e1.uns; req_addr = e1.addr;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(e2);
    req_we = e2.we; req_size = e2.sz; req_unsigned = e2.uns; req_addr = e2.addr;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      if (rsp_valid) begin lat = c; break; end
      @(posedge clk); #1;
    end
    e = exp_q.pop_front();
    held = rsp_rdata;
    tests_run++; if (lat != e.lat) begin tests_failed++; $display("FAIL bp first latency got %0d want %0d", lat, e.lat); end
    tests_run++; if (held !== e.rdata) begin tests_failed++; $display("FAIL bp first rdata got %h want %h", held, e.rdata); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      tests_run++; if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL bp hold%0d rsp_valid got %b want 1", k, rsp_valid); end
      tests_run++; if (rsp_rdata !== e.rdata) begin tests_failed++; $display("FAIL bp hold%0d rsp_rdata got %h want %h", k, rsp_rdata, e.rdata); end
      tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL bp hold%0d req_ready got %b want 0", k, req_ready); end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL bp handshake rsp_valid got %b want 0", rsp_valid); end
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL bp handshake req_ready got %b want 1", req_ready); end
    @(posedge clk); #1;
    tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL bp second accept req_ready got %b want 0", req_ready); end
    req_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      if (rsp_valid) begin lat = c; break; end
      @(posedge clk); #1;
    end
    e = exp_q.pop_front();
    tests_run++; if (lat != e.lat) begin tests_failed++; $display("FAIL bp second latency got %0d want %0d", lat, e.lat); end
    tests_run++; if (rsp_rdata !== e.rdata) begin tests_failed++; $display("FAIL bp second rdata got %h want %h", rsp_rdata, e.rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_misaligned();
    acc_t tbl[$];
    acc_t e;
    obs_t o;
`ifdef LSU_ALIGN_CHECK_EN
    tbl.push_back(mk(0, 2'd2, 0, 32'h12, 0,             0, 1, 1, 0, PRELOAD));
    tbl.push_back(mk(0, 2'd1, 0, 32'h11, 0,             0, 1, 1, 0, PRELOAD));
    tbl.push_back(mk(1, 2'd2, 0, 32'h13, 32'h1122_3344, 0, 1, 1, 0, PRELOAD));
    tbl.push_back(mk(1, 2'd1, 0, 32'h13, 32'h0000_ABCD, 0, 1, 1, 0, PRELOAD));
    tbl.push_back(mk(0, 2'd0, 0, 32'h13, 0, 32'hFFFF_FF80, 0, 2, 0, PRELOAD));
`else
    tbl.push_back(mk(0, 2'd2, 0, 32'h12, 0, 32'h8081_7F01, 0, 2, 0, PRELOAD));
    tbl.push_back(mk(0, 2'd1, 0, 32'h11, 0, 32'h0000_7F01, 0, 2, 0, PRELOAD));
    tbl.push_back(mk(0, 2'd1, 1, 32'h13, 0, 32'h0000_8081, 0, 2, 0, PRELOAD));
    tbl.push_back(mk(1, 2'd2, 0, 32'h13, 32'h1122_3344, 0, 0, 2, 1, 32'h1122_3344));
    tbl.push_back(mk(1, 2'd1, 0, 32'h11, 32'h0000_ABCD, 0, 0, 3, 2, 32'h1122_ABCD));
    tbl.push_back(mk(1, 2'd2, 0, 32'h10, PRELOAD,       0, 0, 2, 1, PRELOAD));
`endif
    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i]);
      run_access(tbl[i], o);
      e = exp_q.pop_front();
      tests_run++; if (o.rdata !== e.rdata) begin tests_failed++; $display("FAIL misalign@%h rdata got %h want %h", e.addr, o.rdata, e.rdata); end
      tests_run++; if (o.err !== e.err) begin tests_failed++; $display("FAIL misalign@%h err got %b want %b", e.addr, o.err, e.err); end
      tests_run++; if (o.lat != e.lat) begin tests_failed++; $display("FAIL misalign@%h latency got %0d want %0d", e.addr, o.lat, e.lat); end
      tests_run++; if (o.we_cyc != e.we_cyc) begin tests_failed++; $display("FAIL misalign@%h mem_we cycle got %0d want %0d", e.addr, o.we_cyc, e.we_cyc); end
      tests_run++; if (mem[4] !== e.word) begin tests_failed++; $display("FAIL misalign@%h mem word got %h want %h", e.addr, mem[4], e.word); end
    end
  endtask

  task automatic test_reset_midop();
    int   we_before;
    acc_t e;
    obs_t o;
    we_before = we_total;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h11; req_wdata = 32'h0000_00AA; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL midreset mem_we got %b want 0", mem_we); end
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL midreset req_ready got %b want 1", req_ready); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL midreset release req_ready got %b want 1", req_ready); end
    @(posedge clk); #1;
    tests_run++; if (we_total != we_before) begin tests_failed++; $display("FAIL midreset write count got %0d want %0d", we_total, we_before); end
    tests_run++; if (mem[4] !== PRELOAD) begin tests_failed++; $display("FAIL midreset mem word got %h want %h", mem[4], PRELOAD); end
    e = mk(0, 2'd0, 0, 32'h11, 0, 32'h0000_007F, 0, 2, 0, PRELOAD);
    exp_q.push_back(e);
    run_access(e, o);
    e = exp_q.pop_front();
    tests_run++; if (o.rdata !== e.rdata) begin tests_failed++; $display("FAIL after_reset load rdata got %h want %h", o.rdata, e.rdata); end
    tests_run++; if (o.lat != e.lat) begin tests_failed++; $display("FAIL after_reset load latency got %0d want %0d", o.lat, e.lat); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_back_to_back();
    test_misaligned();
    test_reset_midop();
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL scoreboard leftover got %0d want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lsu_access_ctrl.md
Name: lsu_access_ctrl

Overview:
- Load/store access controller between the multicycle datapath and the word-addressed unified memory.
- The memory has a combinational read, a synchronous write, and ignores addr[1:0].
- Accepts byte, halfword and word loads/stores over a valid/ready request channel and returns results on a valid/ready response channel.
- Implements sub-word stores as read-modify-write and sub-word loads as extract-plus-extend.
- Byte order is little-endian: byte 0 is bits 7:0.

Parameters:
AW, 32, address width of req_addr and mem_addr
DW, 32, data width; fixed at 32, other values unsupported

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_size  in  2  access size, lsu_pkg::size_t (BYTE=0, HALF=1, WORD=2; 3 reserved, treated as WORD)
req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0
req_addr  in  AW  byte address
req_wdata  in  DW  store data, right-justified
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  DW  extended load data; 0 for stores
rsp_err  out  1  misaligned access (feature-dependent)
mem_we  out  1  memory write enable
mem_addr  out  AW  word-aligned address to memory ([1:0] always 0)
mem_wdata  out  DW  full word to write
mem_rdata  in  DW  combinational read word from memory

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE
  - req_ready=1; rsp_valid=0, rsp_rdata=0, rsp_err=0
  - mem_we=0, mem_addr=0, mem_wdata=0
  - Asserting reset mid-operation aborts the access immediately; no write completes after reset assertion.
- All outputs are registered, except req_ready, which decodes state==IDLE.
- States: IDLE, RD, WR, RESP.
- Handshake: a request is accepted when req_valid && req_ready. All req_* fields are captured on that edge and req_* is ignored afterwards.
- Transitions out of IDLE on accept:
  - Load (any size) -> RD.
  - Store WORD -> WR, with mem_wdata=req_wdata.
  - Store BYTE/HALF -> RD.
  - Misaligned with LSU_ALIGN_CHECK_EN defined -> RESP directly, rsp_err=1, no memory cycle.
- RD, one cycle, mem_addr = {addr[AW-1:2],2'b00}:
  - Load: extract lane and extend into the rsp_rdata register, then -> RESP.
  - Store: merge req_wdata lane(s) into mem_rdata to form mem_wdata, then -> WR.
- WR, one cycle: mem_we=1 for exactly this cycle, then -> RESP with mem_we=0.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err stay stable until rsp_valid && rsp_ready, then -> IDLE.
  - No new request is accepted in the handshake cycle.
- Latency, accept edge to rsp_valid rising:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Misaligned error: 1 cycle.
  - The minimum request-to-request interval is therefore the latency plus 1.
- Lane rules:
  - BYTE uses lane addr[1:0].
  - HALF uses lane addr[1] (bits 15:0 or 31:16).
  - Sign extension takes the top bit of the extracted lane.
  - Store merge leaves the other lanes byte-exact.
- Alignment: HALF requires addr[0]=0; WORD requires addr[1:0]=0; BYTE is always aligned.
- Reserved req_size=3 behaves exactly as WORD.
- mem_we is never asserted outside WR.

Optional Feature:
LSU_ALIGN_CHECK_EN
- Defined: a misaligned request goes to RESP with rsp_err=1 and rsp_rdata=0. No memory read or write occurs.
- Undefined: rsp_err is tied 0. Offending low address bits are cleared (HALF clears [0]; WORD clears [1:0]) and the access proceeds normally.

Decomposition:
- lsu_pkg holds:
  - size_t enum {SZ_BYTE, SZ_HALF, SZ_WORD}.
  - state_t enum {IDLE, RD, WR, RESP}.
  - Function is_aligned(size, addr[1:0]).
- One combinational sub-module, lsu_lane, holds all lane logic so the FSM stays lane-agnostic:
  - Inputs: word, size, offset, unsigned flag, store data.
  - Outputs: extended load value and merged store word.

Test Plan:
Memory preloaded with word 0x8081_7F01 at address 0x10.
- lw 0x10 -> rsp_valid 2 cycles after accept; rsp_rdata=0x80817F01, rsp_err=0, mem_we never high.
- lb 0x13 -> 0xFFFFFF80; lbu 0x13 -> 0x00000080; lh 0x12 -> 0xFFFF8081; lhu 0x12 -> 0x00008081; lb 0x11 -> 0x0000007F.
- sb 0x11 wdata 0xFFFFFFAA -> mem_we high exactly 1 cycle (cycle 2, mem_addr=0x10) -> word becomes 0x8081AA01; rsp_valid at cycle 3.
- sh 0x12 wdata 0x1234 -> word 0x12347F01; then sw 0x10 wdata 0xDEADBEEF -> mem_we at cycle 1, word 0xDEADBEEF.
- Backpressure:
  - Hold rsp_ready=0 for 3 cycles after rsp_valid -> rsp_valid/rsp_rdata stable and req_ready=0 throughout.
  - Pending req_valid is accepted only on the first cycle after the response handshake.
- Misaligned lw 0x12:
  - With LSU_ALIGN_CHECK_EN -> rsp_err=1, rsp_rdata=0, latency 1, no mem_we.
  - Without it -> rsp_rdata=0x80817F01.
- Reset mid-operation: assert reset_n=0 during RD of an sb -> mem_we stays 0, word unchanged, req_ready=1 right after release.
